// File: rtl/instr_sequencer.sv
// Fetch/execute sequencer: owns PC and IR, resolves jumps, gates write-back strobes.
// Optional breakpoint support via `define INSTR_SEQ_BREAKPOINT_EN (adds BrkEn/BrkAddr).
module instr_sequencer #(
  parameter logic [7:0] PC_RESET = 8'h00,
  parameter logic [4:0] HALT_OP  = 5'b11111
) (
  input  logic        Clk,
  input  logic        Rst_n,
  input  logic        Run,
  input  logic        Step,
  output logic [7:0]  InstrAddr,
  input  logic [15:0] InstrData,
  output logic [15:0] IR,
  input  logic        JMP,
  input  logic [7:0]  JmpAddress,
  input  logic        WR,
  input  logic        FlagWR,
  input  logic        TakeJump,
`ifdef INSTR_SEQ_BREAKPOINT_EN
  input  logic        BrkEn,
  input  logic [7:0]  BrkAddr,
`endif
  output logic        RegWE,
  output logic        FlagWE,
  output logic [2:0]  State,
  output logic        Halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_LOAD  = 3'd2,
    S_EXEC  = 3'd3,
    S_WB    = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] ir_q, ir_d;
  logic        step_q;
  logic        step_edge;
  logic [7:0]  pc_next;
  logic        brk_hit;

  assign step_edge = Step & ~step_q;
  assign pc_next   = (JMP && TakeJump) ? JmpAddress : pc_q + 8'd1;

`ifdef INSTR_SEQ_BREAKPOINT_EN
  assign brk_hit = BrkEn && (pc_next == BrkAddr);
`else
  assign brk_hit = 1'b0;
`endif

  // The ROM address is a separate register so it only moves on entry to FETCH,
  // even though PC itself advances at the end of WB.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    RegWE   = 1'b0;
    FlagWE  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (Run || step_edge) begin
          state_d = S_FETCH;
          addr_d  = pc_q;
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        ir_d    = InstrData;
        state_d = S_EXEC;
      end
      S_EXEC: state_d = (ir_q[15:11] == HALT_OP) ? S_HALT : S_WB;
      S_WB: begin
        RegWE  = WR;
        FlagWE = FlagWR;
        pc_d   = pc_next;
        if (Run && !brk_hit) begin
          state_d = S_FETCH;
          addr_d  = pc_next;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= PC_RESET;
      addr_q  <= PC_RESET;
      ir_q    <= '0;
      step_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      step_q  <= Step;
    end
  end

  assign InstrAddr = addr_q;
  assign IR        = ir_q;
  assign State     = state_q;
  assign Halted    = (state_q == S_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed self-checking bench for instr_sequencer with a behavioural synchronous ROM.
module tb_instr_sequencer;

  logic        Clk = 1'b0;
  logic        Rst_n, Run, Step;
  logic [7:0]  InstrAddr;
  logic [15:0] InstrData;
  logic [15:0] IR;
  logic        JMP, WR, FlagWR, TakeJump;
  logic [7:0]  JmpAddress;
  logic        RegWE, FlagWE, Halted;
  logic [2:0]  State;
`ifdef INSTR_SEQ_BREAKPOINT_EN
  logic        BrkEn;
  logic [7:0]  BrkAddr;
`endif

  logic [15:0] rom [256];
  int unsigned checks = 0;
  int unsigned failures = 0;

  always #5 Clk = ~Clk;

  always @(posedge Clk) InstrData <= rom[InstrAddr];

  instr_sequencer #(.PC_RESET(8'h00), .HALT_OP(5'b11111)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Step(Step),
    .InstrAddr(InstrAddr), .InstrData(InstrData), .IR(IR),
    .JMP(JMP), .JmpAddress(JmpAddress), .WR(WR), .FlagWR(FlagWR), .TakeJump(TakeJump),
`ifdef INSTR_SEQ_BREAKPOINT_EN
    .BrkEn(BrkEn), .BrkAddr(BrkAddr),
`endif
    .RegWE(RegWE), .FlagWE(FlagWE), .State(State), .Halted(Halted)
  );

  task automatic tick();
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[8'h00] = 16'h0049;
    rom[8'h01] = 16'hA830;
    rom[8'h30] = 16'hB040;
    rom[8'h31] = 16'h0049;
    Rst_n = 1'b0; Run = 1'b0; Step = 1'b0;
    JMP = 1'b0; JmpAddress = 8'h00; WR = 1'b0; FlagWR = 1'b0; TakeJump = 1'b0;
`ifdef INSTR_SEQ_BREAKPOINT_EN
    BrkEn = 1'b0; BrkAddr = 8'h00;
`endif

    // Reset state
    repeat (2) tick();
    chk("rst_state", 16'(State), 16'd0);
    chk("rst_addr", 16'(InstrAddr), 16'h00);
    chk("rst_ir", IR, 16'h0000);
    chk("rst_regwe", 16'(RegWE), 16'd0);
    chk("rst_flagwe", 16'(FlagWE), 16'd0);
    chk("rst_halted", 16'(Halted), 16'd0);
    Rst_n = 1'b1;
    repeat (5) tick();
    chk("idle_state", 16'(State), 16'd0);
    chk("idle_addr", 16'(InstrAddr), 16'h00);
    chk("idle_regwe", 16'(RegWE), 16'd0);

    // Straight-line ADD with Run
    WR = 1'b1; FlagWR = 1'b1; Run = 1'b1;
    tick(); chk("add_fetch_state", 16'(State), 16'd1);
    chk("add_fetch_addr", 16'(InstrAddr), 16'h00);
    tick(); chk("add_load_state", 16'(State), 16'd2);
    tick(); chk("add_exec_state", 16'(State), 16'd3);
    chk("add_exec_ir", IR, 16'h0049);
    chk("add_exec_regwe", 16'(RegWE), 16'd0);
    tick(); chk("add_wb_state", 16'(State), 16'd4);
    chk("add_wb_regwe", 16'(RegWE), 16'd1);
    chk("add_wb_flagwe", 16'(FlagWE), 16'd1);
    tick(); chk("add_next_state", 16'(State), 16'd1);
    chk("add_next_addr", 16'(InstrAddr), 16'h01);
    chk("add_next_regwe", 16'(RegWE), 16'd0);

    // Taken JUMP to 8'h30
    JMP = 1'b1; JmpAddress = 8'h30; TakeJump = 1'b1; WR = 1'b0; FlagWR = 1'b0;
    rom[8'h00] = 16'hF800;
    tick(); tick(); chk("jmp_exec_ir", IR, 16'hA830);
    tick(); chk("jmp_wb_regwe", 16'(RegWE), 16'd0);
    tick(); chk("jmp_fetch_addr", 16'(InstrAddr), 16'h30);

    // Untaken JE falls through
    JmpAddress = 8'h40; TakeJump = 1'b0;
    tick(); tick(); chk("je_exec_ir", IR, 16'hB040);
    tick(); tick(); chk("je_fetch_addr", 16'(InstrAddr), 16'h31);
    chk("je_fetch_state", 16'(State), 16'd1);

    // Run dropped during LOAD: instruction completes, then IDLE
    JMP = 1'b0; WR = 1'b1;
    tick(); Run = 1'b0;
    tick(); tick(); chk("rundrop_wb_state", 16'(State), 16'd4);
    chk("rundrop_wb_regwe", 16'(RegWE), 16'd1);
    tick(); chk("rundrop_idle_state", 16'(State), 16'd0);
    chk("rundrop_idle_addr", 16'(InstrAddr), 16'h31);
    chk("rundrop_idle_regwe", 16'(RegWE), 16'd0);
    repeat (3) tick();
    chk("rundrop_stay_idle", 16'(State), 16'd0);

    // Single step
    Step = 1'b1;
    tick(); chk("step_fetch_state", 16'(State), 16'd1);
    chk("step_fetch_addr", 16'(InstrAddr), 16'h32);
    repeat (3) tick();
    tick(); chk("step_done_state", 16'(State), 16'd0);
    repeat (2) tick();
    chk("step_held_no_retrigger", 16'(State), 16'd0);
    Step = 1'b0; tick(); Step = 1'b1;
    tick(); chk("step2_fetch_addr", 16'(InstrAddr), 16'h33);
    Step = 1'b0; tick(); Step = 1'b1;
    tick(); tick(); tick(); chk("step2_idle_state", 16'(State), 16'd0);
    tick(); chk("step_edge_discarded", 16'(State), 16'd0);

    // Jump to 8'hFF, then wrap to 8'h00 and hit HALT
    JMP = 1'b1; TakeJump = 1'b1; JmpAddress = 8'hFF;
    Step = 1'b0; tick(); Step = 1'b1;
    tick(); chk("wrapjmp_fetch_addr", 16'(InstrAddr), 16'h34);
    repeat (3) tick();
    tick(); chk("wrapjmp_idle_addr", 16'(InstrAddr), 16'h34);
    JMP = 1'b0; Run = 1'b1;
    tick(); chk("wrap_fetch_ff", 16'(InstrAddr), 16'hFF);
    repeat (3) tick();
    tick(); chk("wrap_fetch_00", 16'(InstrAddr), 16'h00);
    WR = 1'b1;
    tick(); tick(); chk("halt_exec_ir", IR, 16'hF800);
    tick(); chk("halt_state", 16'(State), 16'd5);
    chk("halt_halted", 16'(Halted), 16'd1);
    chk("halt_regwe", 16'(RegWE), 16'd0);
    repeat (3) tick();
    chk("halt_stay_state", 16'(State), 16'd5);
    chk("halt_stay_addr", 16'(InstrAddr), 16'h00);

    // Async reset out of HALT
    #2 Rst_n = 1'b0;
    #1 chk("halt_async_state", 16'(State), 16'd0);
    chk("halt_async_halted", 16'(Halted), 16'd0);
    rom[8'h00] = 16'h0049;
    @(negedge Clk) Rst_n = 1'b1;

    // Async reset mid-WB drops RegWE immediately
    tick(); chk("wbrst_fetch_addr", 16'(InstrAddr), 16'h00);
    repeat (3) tick();
    chk("wbrst_pre_regwe", 16'(RegWE), 16'd1);
    #2 Rst_n = 1'b0;
    #1 chk("wbrst_regwe", 16'(RegWE), 16'd0);
    chk("wbrst_state", 16'(State), 16'd0);
    chk("wbrst_ir", IR, 16'h0000);
    Run = 1'b0;
    @(negedge Clk) Rst_n = 1'b1;

`ifdef INSTR_SEQ_BREAKPOINT_EN
    rom[8'h01] = 16'h0049;
    rom[8'h02] = 16'h0049;
    BrkEn = 1'b1; BrkAddr = 8'h02; Run = 1'b1;
    repeat (4) tick();
    tick(); chk("brk_fetch1_addr", 16'(InstrAddr), 16'h01);
    repeat (3) tick();
    tick(); chk("brk_idle_state", 16'(State), 16'd0);
    chk("brk_idle_addr", 16'(InstrAddr), 16'h01);
    Run = 1'b0; Step = 1'b0;
    tick(); Step = 1'b1;
    tick(); chk("brk_step_addr", 16'(InstrAddr), 16'h02);
    repeat (3) tick();
    tick(); chk("brk_step_done", 16'(State), 16'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
